// File: rtl/alu_writeback.sv
// ALU writeback: accumulator, masked flag register, condition decode and an
// optional flag shadow stack (built only when FLAG_STACK_EN is defined).
module alu_writeback #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags,
    input  logic       acc_we,
    input  logic       flag_we,
    input  logic [3:0] flag_mask,
    input  logic       flag_push,
    input  logic       flag_pop,
    input  logic       err_clr,
    input  logic [2:0] cond_sel,
    output logic [7:0] acc_q,
    output logic [3:0] flag_q,
    output logic       cin_out,
    output logic       cond_true,
    output logic       stk_full,
    output logic       stk_empty,
    output logic       stk_err
);

    logic [7:0] acc_d;
    logic [3:0] flag_d;
    logic [3:0] flag_upd;
    logic       pop_ok;
    logic [3:0] pop_val;

    // Accumulator next value: capture ALU result on acc_we.
    always_comb begin
        acc_d = acc_we ? alu_out : acc_q;
    end

    // Masked flag update; a successful pop wins over flag_we.
    always_comb begin
        flag_upd = (alu_flags & flag_mask) | (flag_q & ~flag_mask);
        flag_d   = flag_we ? flag_upd : flag_q;
        if (pop_ok) begin
            flag_d = pop_val;
        end
    end

    // Accumulator and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= 8'h00;
            flag_q <= 4'h0;
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
        end
    end

    assign cin_out = flag_q[1];

    // Branch condition decode from the registered flags {P, S, C, Z}.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond_sel)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flag_q[0];
            3'b010: cond_true = ~flag_q[0];
            3'b011: cond_true = flag_q[1];
            3'b100: cond_true = ~flag_q[1];
            3'b101: cond_true = flag_q[2];
            3'b110: cond_true = ~flag_q[2];
            3'b111: cond_true = flag_q[3];
            default: cond_true = 1'b0;
        endcase
    end

`ifdef FLAG_STACK_EN

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stk_err_q;
    logic          stk_err_d;
    logic [3:0]    stk_mem_q [STACK_DEPTH];
    logic          push_req;
    logic          pop_req;
    logic          push_ok;
    logic          err_new;
    logic          full;
    logic          empty;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // Stack control: simultaneous push and pop cancel each other out.
    always_comb begin
        full     = (cnt_q == CW'(STACK_DEPTH));
        empty    = (cnt_q == '0);
        push_req = flag_push & ~flag_pop;
        pop_req  = flag_pop & ~flag_push;
        push_ok  = push_req & ~full;
        pop_ok   = pop_req & ~empty;
        err_new  = (push_req & full) | (pop_req & empty);
        wr_idx   = AW'(cnt_q);
        rd_idx   = AW'(cnt_q - CW'(1));
        pop_val  = stk_mem_q[rd_idx];
    end

    // Occupancy and sticky error next state; a new error beats err_clr.
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
        stk_err_d = err_new | (stk_err_q & ~err_clr);
    end

    // Occupancy counter and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            stk_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stk_err_q <= stk_err_d;
        end
    end

    // Stack entries hold the pre-edge flag value; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stk_mem_q[wr_idx] <= flag_q;
        end
    end

    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = stk_err_q;

`else

    logic unused_stack;

    assign pop_ok       = 1'b0;
    assign pop_val      = 4'h0;
    assign stk_full     = 1'b0;
    assign stk_empty    = 1'b1;
    assign stk_err      = 1'b0;
    assign unused_stack = ^{flag_push, flag_pop, err_clr, (STACK_DEPTH > 16)};

`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: scoreboard of expected register
// state plus directed scenario checks, with or without FLAG_STACK_EN.
module tb_alu_writeback;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_out = '0;
    logic [3:0] alu_flags = '0;
    logic       acc_we = 1'b0;
    logic       flag_we = 1'b0;
    logic [3:0] flag_mask = '0;
    logic       flag_push = 1'b0;
    logic       flag_pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] cond_sel = '0;
    logic [7:0] acc_q;
    logic [3:0] flag_q;
    logic       cin_out;
    logic       cond_true;
    logic       stk_full;
    logic       stk_empty;
    logic       stk_err;

    alu_writeback #(.STACK_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alu_out(alu_out),
        .alu_flags(alu_flags),
        .acc_we(acc_we),
        .flag_we(flag_we),
        .flag_mask(flag_mask),
        .flag_push(flag_push),
        .flag_pop(flag_pop),
        .err_clr(err_clr),
        .cond_sel(cond_sel),
        .acc_q(acc_q),
        .flag_q(flag_q),
        .cin_out(cin_out),
        .cond_true(cond_true),
        .stk_full(stk_full),
        .stk_empty(stk_empty),
        .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] acc;
        logic [3:0] flag;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] m_acc = '0;
    logic [3:0] m_flag = '0;
    logic       m_err = 1'b0;
    logic [3:0] m_stk[$];
    int         checks = 0;
    int         errors = 0;

    // Scoreboard monitor: compare registered outputs one step after each edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (acc_q !== mon_e.acc) begin
                errors++;
                $display("FAIL sb_acc got %h exp %h t=%0t", acc_q, mon_e.acc, $time);
            end
            checks++;
            if (flag_q !== mon_e.flag) begin
                errors++;
                $display("FAIL sb_flag got %h exp %h t=%0t", flag_q, mon_e.flag, $time);
            end
            checks++;
            if (cin_out !== mon_e.flag[1]) begin
                errors++;
                $display("FAIL sb_cin got %b exp %b t=%0t", cin_out, mon_e.flag[1], $time);
            end
            checks++;
            if (stk_full !== mon_e.full) begin
                errors++;
                $display("FAIL sb_full got %b exp %b t=%0t", stk_full, mon_e.full, $time);
            end
            checks++;
            if (stk_empty !== mon_e.empty) begin
                errors++;
                $display("FAIL sb_empty got %b exp %b t=%0t", stk_empty, mon_e.empty, $time);
            end
            checks++;
            if (stk_err !== mon_e.err) begin
                errors++;
                $display("FAIL sb_err got %b exp %b t=%0t", stk_err, mon_e.err, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_acc  = '0;
        m_flag = '0;
        m_err  = 1'b0;
        m_stk.delete();
    endtask

    // Drive one cycle of controls, update the model, queue the expectation.
    task automatic drive(input logic we, input logic [7:0] a, input logic fwe,
                         input logic [3:0] f, input logic [3:0] m,
                         input logic pu, input logic po, input logic clr);
        exp_t       e;
        logic [3:0] nf;
        acc_we    = we;
        alu_out   = a;
        flag_we   = fwe;
        alu_flags = f;
        flag_mask = m;
        flag_push = pu;
        flag_pop  = po;
        err_clr   = clr;
        if (we) m_acc = a;
        nf = fwe ? ((f & m) | (m_flag & ~m)) : m_flag;
`ifdef FLAG_STACK_EN
        if (clr) m_err = 1'b0;
        if (pu && !po) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else m_stk.push_back(m_flag);
        end
        if (po && !pu) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else nf = m_stk.pop_back();
        end
`endif
        m_flag  = nf;
        e.acc   = m_acc;
        e.flag  = m_flag;
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (acc_q !== 8'h00 || flag_q !== 4'h0 || cin_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs acc %h flag %h cin %b exp 00 0 0", acc_q, flag_q, cin_out);
        end
        checks++;
        if (stk_empty !== 1'b1 || stk_full !== 1'b0 || stk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_stk e/f/err %b%b%b exp 100", stk_empty, stk_full, stk_err);
        end
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'(i);
            cond_sel = s;
            #1;
            checks++;
            if (cond_true !== ~s[0]) begin
                errors++;
                $display("FAIL reset_cond sel %0d got %b exp %b", i, cond_true, ~s[0]);
            end
        end
        cond_sel = 3'b000;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_acc();
        drive(1'b1, 8'hA5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_q !== 8'hA5 || flag_q !== 4'h0) begin
            errors++;
            $display("FAIL acc_load acc %h flag %h exp a5 0", acc_q, flag_q);
        end
        drive(1'b0, 8'h3C, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_q !== 8'hA5) begin
            errors++;
            $display("FAIL acc_hold got %h exp a5", acc_q);
        end
    endtask

    task automatic test_flag_mask();
        drive(1'b0, 8'h00, 1'b1, 4'hF, 4'b0010, 1'b0, 1'b0, 1'b0);
        cond_sel = 3'b011;
        #1;
        checks++;
        if (flag_q !== 4'b0010 || cin_out !== 1'b1 || cond_true !== 1'b1) begin
            errors++;
            $display("FAIL flag_mask flag %b cin %b cond %b exp 0010 1 1",
                     flag_q, cin_out, cond_true);
        end
        drive(1'b0, 8'h00, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flag_q !== 4'b0010) begin
            errors++;
            $display("FAIL flag_mask0 got %b exp 0010", flag_q);
        end
        drive(1'b0, 8'h00, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        checks++;
        if (flag_q !== 4'b0010) begin
            errors++;
            $display("FAIL flag_we0 got %b exp 0010", flag_q);
        end
    endtask

    task automatic test_cond();
        logic [3:0] pats [4];
        logic       ex;
        pats = '{4'h5, 4'hA, 4'hF, 4'h0};
        for (int p = 0; p < 4; p++) begin
            drive(1'b0, 8'h00, 1'b1, pats[p], 4'hF, 1'b0, 1'b0, 1'b0);
            for (int s = 0; s < 8; s++) begin
                cond_sel = 3'(s);
                case (s)
                    0: ex = 1'b1;
                    1: ex = pats[p][0];
                    2: ex = !pats[p][0];
                    3: ex = pats[p][1];
                    4: ex = !pats[p][1];
                    5: ex = pats[p][2];
                    6: ex = !pats[p][2];
                    default: ex = pats[p][3];
                endcase
                #1;
                checks++;
                if (cond_true !== ex) begin
                    errors++;
                    $display("FAIL cond flags %h sel %0d got %b exp %b",
                             pats[p], s, cond_true, ex);
                end
            end
        end
        cond_sel = 3'b000;
    endtask

`ifdef FLAG_STACK_EN
    task automatic test_stack();
        logic [3:0] exp_pop [4];
        exp_pop = '{4'h4, 4'h3, 4'h2, 4'h1};
        drive(1'b0, 8'h00, 1'b1, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stk_full !== 1'b1 || stk_err !== 1'b0) begin
            errors++;
            $display("FAIL stk_fill full %b err %b exp 1 0", stk_full, stk_err);
        end
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stk_err !== 1'b1 || stk_full !== 1'b1) begin
            errors++;
            $display("FAIL stk_ovf err %b full %b exp 1 1", stk_err, stk_full);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
            checks++;
            if (flag_q !== exp_pop[i]) begin
                errors++;
                $display("FAIL stk_pop%0d got %h exp %h", i, flag_q, exp_pop[i]);
            end
        end
        checks++;
        if (stk_empty !== 1'b1) begin
            errors++;
            $display("FAIL stk_drain empty %b exp 1", stk_empty);
        end
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 4'h8, 4'hF, 1'b0, 1'b1, 1'b0);
        checks++;
        if (stk_err !== 1'b1 || flag_q !== 4'h8) begin
            errors++;
            $display("FAIL stk_unf err %b flag %h exp 1 8", stk_err, flag_q);
        end
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (stk_err !== 1'b1) begin
            errors++;
            $display("FAIL stk_clr_vs_err got %b exp 1", stk_err);
        end
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (stk_err !== 1'b0) begin
            errors++;
            $display("FAIL stk_clr got %b exp 0", stk_err);
        end
        drive(1'b0, 8'h00, 1'b1, 4'h6, 4'hF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 4'h9, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 4'hC, 4'hF, 1'b1, 1'b1, 1'b0);
        checks++;
        if (flag_q !== 4'hC || stk_empty !== 1'b0 || stk_err !== 1'b0) begin
            errors++;
            $display("FAIL stk_pushpop flag %h empty %b err %b exp c 0 0",
                     flag_q, stk_empty, stk_err);
        end
        drive(1'b0, 8'h00, 1'b1, 4'h9, 4'hF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        checks++;
        if (flag_q !== 4'h6 || stk_empty !== 1'b1) begin
            errors++;
            $display("FAIL stk_pop_wins flag %h empty %b exp 6 1", flag_q, stk_empty);
        end
    endtask
`else
    task automatic test_no_stack();
        drive(1'b0, 8'h00, 1'b1, 4'h9, 4'hF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (flag_q !== 4'h9) begin
            errors++;
            $display("FAIL nostk_flag got %h exp 9", flag_q);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (stk_empty !== 1'b1 || stk_full !== 1'b0 || stk_err !== 1'b0
            || flag_q !== 4'h9) begin
            errors++;
            $display("FAIL nostk_const e/f/err %b%b%b flag %h exp 100 9",
                     stk_empty, stk_full, stk_err, flag_q);
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1) == 1, 8'($urandom),
                  $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h5A, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        acc_we    = 1'b1;
        alu_out   = 8'h77;
        flag_push = 1'b1;
        flag_we   = 1'b1;
        alu_flags = 4'hE;
        flag_mask = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (acc_q !== 8'h00 || flag_q !== 4'h0 || cin_out !== 1'b0) begin
            errors++;
            $display("FAIL areset_regs acc %h flag %h cin %b exp 00 0 0", acc_q, flag_q, cin_out);
        end
        checks++;
        if (stk_empty !== 1'b1 || stk_full !== 1'b0 || stk_err !== 1'b0) begin
            errors++;
            $display("FAIL areset_stk e/f/err %b%b%b exp 100", stk_empty, stk_full, stk_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (acc_q !== 8'h00 || stk_empty !== 1'b1) begin
            errors++;
            $display("FAIL areset_hold acc %h empty %b exp 00 1", acc_q, stk_empty);
        end
        rst_n = 1'b1;
        drive(1'b1, 8'h11, 1'b1, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0);
        checks++;
        if (acc_q !== 8'h11 || flag_q !== 4'h3) begin
            errors++;
            $display("FAIL areset_release acc %h flag %h exp 11 3", acc_q, flag_q);
        end
    endtask

    initial begin
        test_reset();
        test_acc();
        test_flag_mask();
        test_cond();
`ifdef FLAG_STACK_EN
        test_stack();
`else
        test_no_stack();
`endif
        test_back_to_back();
        test_async_reset();
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #20;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: STACK_DEPTH, default 4, number of entries in the flag shadow stack (legal 2..16).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 alu_out  input  8  ALU result byte.
REQ-005 alu_flags  input  4  ALU flags {OddParity, Positive, Cout, Zero}, bit 3..0.
REQ-006 acc_we  input  1  capture alu_out into accumulator.
REQ-007 flag_we  input  1  update flag register from alu_flags under flag_mask.
REQ-008 flag_mask  input  4  per-bit flag update enable, same bit order as alu_flags.
REQ-009 flag_push  input  1  push current flag register onto shadow stack.
REQ-010 flag_pop  input  1  restore flag register from top of shadow stack.
REQ-011 err_clr  input  1  clear sticky stack error.
REQ-012 cond_sel  input  3  branch condition select.
REQ-013 acc_q  output  8  registered accumulator.
REQ-014 flag_q  output  4  registered flags {P, S, C, Z}.
REQ-015 cin_out  output  1  carry feedback to ALU Cin, equal to flag_q[1].
REQ-016 cond_true  output  1  combinational condition result from flag_q.
REQ-017 stk_full / stk_empty  output  1 each  shadow stack occupancy status.
REQ-018 stk_err  output  1  sticky overflow/underflow indicator.

Function
REQ-019 acc_q SHALL load alu_out on the rising edge where acc_we=1; otherwise hold; latency one cycle.
REQ-020 On flag_we=1 (no pop), each flag_q[i] SHALL load alu_flags[i] when flag_mask[i]=1, else hold.
REQ-021 cond_true SHALL decode cond_sel: 000 always 1; 001 Z; 010 not Z; 011 C; 100 not C; 101 S (positive); 110 not S; 111 P (odd parity).
REQ-022 Stack SHALL be LIFO with occupancy counter 0..STACK_DEPTH; stk_empty = (count==0), stk_full = (count==STACK_DEPTH).
REQ-023 Push (flag_push=1, flag_pop=0, not full) SHALL store the pre-edge flag_q value and increment count; a same-cycle flag_we still updates flag_q.
REQ-024 Pop (flag_pop=1, flag_push=0, not empty) SHALL load flag_q from top entry and decrement count; pop SHALL override a same-cycle flag_we.
REQ-025 flag_push and flag_pop asserted together SHALL be a no-op for the stack and flag_q from the pop path; flag_we then applies normally; no error.
REQ-026 Push when full or pop when empty SHALL leave stack and count unchanged, set stk_err, and (pop case) leave flag_q governed by flag_we only.
REQ-027 stk_err SHALL stay set until err_clr=1; err_clr and a new error in the same cycle SHALL leave stk_err=1.
REQ-028 acc_we SHALL be independent of all flag/stack controls.

Reset
REQ-029 rst_n=0 SHALL immediately force acc_q=8'h00, flag_q=4'h0, count=0, stk_err=0, independent of clk.
REQ-030 After reset: stk_empty=1, stk_full=0, cin_out=0, cond_true=1 only for cond_sel 000, 010, 100, 110.
REQ-031 Reset mid-push/pop SHALL discard the operation; stack entry contents need not be reset.
REQ-032 Release of rst_n SHALL be followed by normal operation on the next rising clk edge.

Configuration
REQ-033 Macro FLAG_STACK_EN: when defined, shadow stack per REQ-022..027 is built.
REQ-034 When FLAG_STACK_EN is undefined, no stack storage SHALL exist; flag_push/flag_pop ignored; stk_empty=1, stk_full=0, stk_err=0 constantly; err_clr ignored.

Verification
REQ-035 Reset then acc_we=1, alu_out=8'hA5 -> acc_q=8'hA5 one cycle later, flag_q=4'h0 unchanged.
REQ-036 flag_q=4'h0, flag_we=1, alu_flags=4'hF, flag_mask=4'b0010 -> flag_q=4'b0010, cin_out=1, cond_sel=011 gives cond_true=1.
REQ-037 Push flags 4'h1,4'h2,4'h3,4'h4 (depth 4) -> stk_full=1; fifth push -> stk_err=1, count stays 4; four pops -> flag_q 4'h4,4'h3,4'h2,4'h1 in turn, stk_empty=1.
REQ-038 Empty stack, flag_pop=1 with flag_we=1, alu_flags=4'h8, mask 4'hF -> stk_err=1, flag_q=4'h8; err_clr=1 -> stk_err=0 next cycle.
REQ-039 Stack holds 4'h6, flag_q=4'h9, flag_pop=1 and flag_we=1 (alu_flags=4'h0) -> flag_q=4'h6, stk_empty=1.
REQ-040 Assert rst_n=0 between clock edges during a push -> all outputs reach reset values before next edge; build without FLAG_STACK_EN -> push/pop leave flag_q and stk_* at constants.
